imm_encode_seq: RTL and testbench

Immediate encoder and instruction sequencer: turns a symbolic request (kind, registers, 32-bit value) into one or two legal RV32I instruction words. Immediate-field packing is the exact inverse of the pipeline's immediate decode (I/U/J/B/S layouts), with range/alignment checking. `li` requests expand into LUI/ADDI pairs with carry correction. Used by the test-program generator and the boot-stub ROM builder in front of instruction memory; output is a valid/ready stream.

---
 rtl/imm_encode_seq.sv | 183 ++++++++++++++++++
 tb/tb_imm_encode_seq.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encode_seq.sv
// imm_encode_seq: encodes a symbolic request into one or two RV32I words.
// LI expands into LUI/ADDI with carry correction of the upper part; ADDI,
// JAL, BRANCH and STORE pack their immediates with range/alignment checks.
// Output is a valid/ready stream; rejected requests give a one-cycle err pulse.
module imm_encode_seq #(
    parameter logic LI_COMPACT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_kind,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic        out_last,
    output logic        err
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] K_LI     = 3'd0;
    localparam logic [2:0] K_ADDI   = 3'd1;
    localparam logic [2:0] K_JAL    = 3'd2;
    localparam logic [2:0] K_BRANCH = 3'd3;
    localparam logic [2:0] K_STORE  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_ERR
    } state_t;

    state_t      r_state;
    logic        r_req_ready;
    logic        r_out_valid;
    logic        r_out_last;
    logic        r_err;
    logic        r_two;
    logic [31:0] r_out_inst;
    logic [31:0] r_second;

    // A value fits an N-bit signed field when bits [31:N-1] are all equal.
    logic        w_fit12;
    logic        w_fit13;
    logic        w_fit21;
    logic [11:0] w_lo;
    logic [19:0] w_hi;
    logic [31:0] w_first;
    logic [31:0] w_second;
    logic        w_two;
    logic        w_bad;

    assign w_fit12 = (&req_value[31:11]) | ~(|req_value[31:11]);
    assign w_fit13 = (&req_value[31:12]) | ~(|req_value[31:12]);
    assign w_fit21 = (&req_value[31:20]) | ~(|req_value[31:20]);
    assign w_lo    = req_value[11:0];
    // ADDI sign-extends lo, so the upper part absorbs a borrow when lo[11]=1;
    // the sum wraps mod 2^20 on purpose.
    assign w_hi    = req_value[31:12] + {19'd0, req_value[11]};

    // Encode the presented request; only sampled when it is accepted.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves one unassigned and infers a latch.
        w_first  = 32'd0;
        w_second = 32'd0;
        w_two    = 1'b0;
        w_bad    = 1'b0;
        case (req_kind)
            K_LI: begin
                if (LI_COMPACT && w_fit12) begin
                    w_first = {w_lo, 5'd0, 3'b000, req_rd, OP_IMM};
                end else if (LI_COMPACT && (w_lo == 12'd0)) begin
                    w_first = {w_hi, req_rd, OP_LUI};
                end else begin
                    w_first  = {w_hi, req_rd, OP_LUI};
                    w_second = {w_lo, req_rd, 3'b000, req_rd, OP_IMM};
                    w_two    = 1'b1;
                end
            end
            K_ADDI: begin
                w_first = {req_value[11:0], req_rs1, 3'b000, req_rd, OP_IMM};
                w_bad   = ~w_fit12;
            end
            K_JAL: begin
                w_first = {req_value[20], req_value[10:1], req_value[11],
                           req_value[19:12], req_rd, OP_JAL};
                w_bad   = ~w_fit21 | req_value[0];
            end
            K_BRANCH: begin
                w_first = {req_value[12], req_value[10:5], req_rs2, req_rs1,
                           req_funct3, req_value[4:1], req_value[11], OP_BRANCH};
                w_bad   = ~w_fit13 | req_value[0];
            end
            K_STORE: begin
                w_first = {req_value[11:5], req_rs2, req_rs1, req_funct3,
                           req_value[4:0], OP_STORE};
                w_bad   = ~w_fit12;
            end
            default: w_bad = 1'b1;
        endcase
    end

    // Sequencer FSM with all stream outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_err       <= 1'b0;
            r_two       <= 1'b0;
            r_out_inst  <= 32'd0;
            r_second    <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every register here sees the
            // pre-edge values of the others, independent of statement order.
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_req_ready <= 1'b0;
                        if (w_bad) begin
                            r_state <= S_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state     <= S_FIRST;
                            r_out_valid <= 1'b1;
                            r_out_inst  <= w_first;
                            r_second    <= w_second;
                            r_two       <= w_two;
                            r_out_last  <= ~w_two;
                        end
                    end
                end
                S_FIRST: begin
                    if (out_ready) begin
                        if (r_two) begin
                            r_state    <= S_SECOND;
                            r_out_inst <= r_second;
                            r_out_last <= 1'b1;
                        end else begin
                            r_state     <= S_IDLE;
                            r_req_ready <= 1'b1;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                S_SECOND: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_req_ready <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_err       <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_last  = r_out_last;
    assign err       = r_err;

endmodule

// File: tb/tb_imm_encode_seq.sv
// Directed bench for imm_encode_seq: one compact-LI instance and one
// LI_COMPACT=0 instance sharing request fields but with their own handshakes.
module tb_imm_encode_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, nc_req_valid;
    logic [2:0]  req_kind;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [31:0] req_value;
    logic        out_ready, nc_out_ready;

    logic        req_ready, out_valid, out_last, err;
    logic [31:0] out_inst;
    logic        nc_req_ready, nc_out_valid, nc_out_last, nc_err;
    logic [31:0] nc_out_inst;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    imm_encode_seq #(.LI_COMPACT(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_funct3(req_funct3), .req_value(req_value),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_last(out_last), .err(err)
    );

    imm_encode_seq #(.LI_COMPACT(1'b0)) dut_nc (
        .clk(clk), .rst_n(rst_n),
        .req_valid(nc_req_valid), .req_ready(nc_req_ready),
        .req_kind(req_kind), .req_rd(req_rd), .req_rs1(req_rs1),
        .req_rs2(req_rs2), .req_funct3(req_funct3), .req_value(req_value),
        .out_valid(nc_out_valid), .out_ready(nc_out_ready), .out_inst(nc_out_inst),
        .out_last(nc_out_last), .err(nc_err)
    );

    // Present one request at a falling edge; it is accepted on the next rising edge.
    task automatic send(input bit nc, input logic [2:0] k, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [2:0] f3, input logic [31:0] v);
        int t;
        @(negedge clk);
        req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_value = v;
        t = 0;
        while (((nc ? nc_req_ready : req_ready) !== 1'b1) && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_chk++;
        if (t >= 20) begin
            $display("FAIL send_timeout: req_ready never rose (nc=%0d)", nc);
            n_err++;
        end
        if (nc) nc_req_valid = 1'b1;
        else    req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        nc_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; nc_req_valid = 1'b0;
        out_ready = 1'b1; nc_out_ready = 1'b1;
        req_kind = 3'd0; req_rd = 5'd0; req_rs1 = 5'd0; req_rs2 = 5'd0;
        req_funct3 = 3'd0; req_value = 32'd0;
        #12;
        n_chk++;
        if ({req_ready, out_valid, out_last, err} !== 4'b1000 || out_inst !== 32'd0) begin
            $display("FAIL reset: ready/valid/last/err=%b inst=%h, want 1000 inst=0",
                     {req_ready, out_valid, out_last, err}, out_inst);
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_li_pair;
        send(1'b0, 3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || {out_last, out_inst} !== {1'b0, 32'h123462B7} || req_ready !== 1'b0) begin
            $display("FAIL li_pair_w0: valid=%b last=%b inst=%h ready=%b, want 1 0 123462b7 0",
                     out_valid, out_last, out_inst, req_ready);
            n_err++;
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || {out_last, out_inst} !== {1'b1, 32'hFFF28293}) begin
            $display("FAIL li_pair_w1: valid=%b last=%b inst=%h, want 1 1 fff28293",
                     out_valid, out_last, out_inst);
            n_err++;
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL li_pair_done: valid=%b ready=%b, want 0 1", out_valid, req_ready);
            n_err++;
        end
    endtask

    task automatic test_li_compact;
        logic [31:0] vals [2] = '{32'hFFFFF800, 32'h00010000};
        logic [4:0]  rds  [2] = '{5'd1, 5'd2};
        logic [31:0] exps [2] = '{32'h80000093, 32'h00010137};
        for (int i = 0; i < 2; i++) begin
            send(1'b0, 3'd0, rds[i], 5'd0, 5'd0, 3'd0, vals[i]);
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || {out_last, out_inst} !== {1'b1, exps[i]}) begin
                $display("FAIL li_compact[%0d]: valid=%b last=%b inst=%h, want 1 1 %h",
                         i, out_valid, out_last, out_inst, exps[i]);
                n_err++;
            end
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin
                $display("FAIL li_compact_single[%0d]: valid=%b, want 0", i, out_valid);
                n_err++;
            end
        end
    endtask

    task automatic test_li_full;
        logic [31:0] vals [2] = '{32'hFFFFF800, 32'h00010000};
        logic [4:0]  rds  [2] = '{5'd1, 5'd2};
        logic [31:0] exp0 [2] = '{32'h000000B7, 32'h00010137};
        logic [31:0] exp1 [2] = '{32'h80008093, 32'h00010113};
        for (int i = 0; i < 2; i++) begin
            send(1'b1, 3'd0, rds[i], 5'd0, 5'd0, 3'd0, vals[i]);
            @(negedge clk);
            n_chk++;
            if (nc_out_valid !== 1'b1 || {nc_out_last, nc_out_inst} !== {1'b0, exp0[i]}) begin
                $display("FAIL li_full_w0[%0d]: valid=%b last=%b inst=%h, want 1 0 %h",
                         i, nc_out_valid, nc_out_last, nc_out_inst, exp0[i]);
                n_err++;
            end
            @(negedge clk);
            n_chk++;
            if (nc_out_valid !== 1'b1 || {nc_out_last, nc_out_inst} !== {1'b1, exp1[i]}) begin
                $display("FAIL li_full_w1[%0d]: valid=%b last=%b inst=%h, want 1 1 %h",
                         i, nc_out_valid, nc_out_last, nc_out_inst, exp1[i]);
                n_err++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_encode;
        logic [2:0]  kinds [7] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
        logic [4:0]  rds   [7] = '{5'd3, 5'd3, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [4:0]  rs1s  [7] = '{5'd4, 5'd4, 5'd0, 5'd0, 5'd1, 5'd0, 5'd2};
        logic [4:0]  rs2s  [7] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd2, 5'd0, 5'd3};
        logic [2:0]  f3s   [7] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2};
        logic [31:0] vals  [7] = '{32'd2047, 32'hFFFFF800, 32'h00000800, 32'hFFF00000,
                                   32'hFFFFFFFC, 32'd4094, 32'hFFFFFFFC};
        logic [31:0] exps  [7] = '{32'h7FF20193, 32'h80020193, 32'h001000EF, 32'h8000006F,
                                   32'hFE208EE3, 32'h7E001FE3, 32'hFE312E23};
        for (int i = 0; i < 7; i++) begin
            send(1'b0, kinds[i], rds[i], rs1s[i], rs2s[i], f3s[i], vals[i]);
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || err !== 1'b0 || {out_last, out_inst} !== {1'b1, exps[i]}) begin
                $display("FAIL encode[%0d]: valid=%b err=%b last=%b inst=%h, want 1 0 1 %h",
                         i, out_valid, err, out_last, out_inst, exps[i]);
                n_err++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_errors;
        logic [2:0]  kinds [10] = '{3'd1, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4, 3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] vals  [10] = '{32'd2048, 32'd3, 32'h00100000, 32'd4096, 32'd5,
                                    32'd2048, 32'hFFFFF7FF, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 10; i++) begin
            send(1'b0, kinds[i], 5'd1, 5'd2, 5'd3, 3'd0, vals[i]);
            @(negedge clk);
            n_chk++;
            if (err !== 1'b1 || out_valid !== 1'b0) begin
                $display("FAIL err_pulse[%0d]: err=%b valid=%b, want 1 0", i, err, out_valid);
                n_err++;
            end
            @(negedge clk);
            n_chk++;
            if (err !== 1'b0 || out_valid !== 1'b0 || req_ready !== 1'b1) begin
                $display("FAIL err_end[%0d]: err=%b valid=%b ready=%b, want 0 0 1",
                         i, err, out_valid, req_ready);
                n_err++;
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        send(1'b0, 3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b1 || {out_last, out_inst} !== {1'b0, 32'h123462B7} || req_ready !== 1'b0) begin
                $display("FAIL bp_hold[%0d]: valid=%b last=%b inst=%h ready=%b, want 1 0 123462b7 0",
                         i, out_valid, out_last, out_inst, req_ready);
                n_err++;
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || {out_last, out_inst} !== {1'b1, 32'hFFF28293} || req_ready !== 1'b0) begin
            $display("FAIL bp_second: valid=%b last=%b inst=%h ready=%b, want 1 1 fff28293 0",
                     out_valid, out_last, out_inst, req_ready);
            n_err++;
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int acc;
        int outs;
        // Single-word requests held back to back: one per two cycles.
        @(negedge clk);
        req_kind = 3'd1; req_rd = 5'd3; req_rs1 = 5'd4; req_value = 32'd7;
        req_valid = 1'b1;
        acc = 0; outs = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            acc  += (req_ready === 1'b1) ? 1 : 0;
            outs += (out_valid === 1'b1) ? 1 : 0;
        end
        req_valid = 1'b0;
        n_chk++;
        if (acc != 5 || outs != 5) begin
            $display("FAIL b2b_single: accepts=%0d words=%0d in 10 cycles, want 5 5", acc, outs);
            n_err++;
        end
        // LI pairs held back to back: one per three cycles.
        @(negedge clk);
        req_kind = 3'd0; req_rd = 5'd5; req_value = 32'h12345FFF;
        req_valid = 1'b1;
        acc = 0; outs = 0;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            acc  += (req_ready === 1'b1) ? 1 : 0;
            outs += (out_valid === 1'b1) ? 1 : 0;
        end
        req_valid = 1'b0;
        n_chk++;
        if (acc != 3 || outs != 6) begin
            $display("FAIL b2b_pair: accepts=%0d words=%0d in 9 cycles, want 3 6", acc, outs);
            n_err++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        send(1'b0, 3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 32'h12345FFF);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || {out_last, out_inst} !== {1'b1, 32'hFFF28293}) begin
            $display("FAIL rst_mid_second: valid=%b last=%b inst=%h, want 1 1 fff28293",
                     out_valid, out_last, out_inst);
            n_err++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1 || out_last !== 1'b0 || out_inst !== 32'd0) begin
            $display("FAIL rst_mid_async: valid=%b ready=%b last=%b inst=%h, want 0 1 0 0",
                     out_valid, req_ready, out_last, out_inst);
            n_err++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(1'b0, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 32'h00000800);
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || {out_last, out_inst} !== {1'b1, 32'h001000EF}) begin
            $display("FAIL rst_mid_after: valid=%b last=%b inst=%h, want 1 1 001000ef",
                     out_valid, out_last, out_inst);
            n_err++;
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            $display("FAIL rst_mid_idle: valid=%b ready=%b, want 0 1", out_valid, req_ready);
            n_err++;
        end
    endtask

    initial begin
        test_reset();
        test_li_pair();
        test_li_compact();
        test_li_full();
        test_encode();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
